// File: rtl/mp3_spi_slave.sv
// VS10xx-style decoder-side serial slave: SCI command registers plus an SDI byte FIFO.
// Inputs cross through 2-flop synchronizers; DREQ is registered and drops when FIFO space runs short.
module mp3_spi_slave #(
    parameter int FIFO_DEPTH = 16,
    parameter int DREQ_FREE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xRSET,
    input  logic        XCS,
    input  logic        XDCS,
    input  logic        SCLK,
    input  logic        SI,
    output logic        SO,
    output logic        DREQ,
    output logic [15:0] mode_reg,
    output logic [15:0] vol_reg,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        sci_err,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SCI_OP, SCI_ADDR, SCI_DATA, SCI_WAIT, SDI} state_t;

    logic [4:0]  sync1_q, sync2_q;
    logic        sclk_prev_q;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] sh_q, so_sh_q, mode_q, vol_q, rd_val;
    logic [7:0]  addr_q, push_dat_q;
    logic        wr_q, so_q, err_q, push_q, dreq_q, ovf_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   fcnt_q, fcnt_d, free;

    // Synchronizers and edge detect run free so they are settled when reset releases.
    always_ff @(posedge clk) begin
        sync1_q     <= {xRSET, XCS, XDCS, SCLK, SI};
        sync2_q     <= sync1_q;
        sclk_prev_q <= sync2_q[1];
    end

    wire xrset_s = sync2_q[4];
    wire xcs_s   = sync2_q[3];
    wire xdcs_s  = sync2_q[2];
    wire si_s    = sync2_q[0];
    wire rise    = sync2_q[1] & ~sclk_prev_q;
    wire fall    = ~sync2_q[1] & sclk_prev_q;
    wire clr     = rst | ~xrset_s;

    wire [15:0] sh_nxt = {sh_q[14:0], si_s};
    wire        full   = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    wire        pop    = data_valid & data_ready;
    wire        push_ok = push_q & (~full | pop);

    assign free = (AW+1)'(FIFO_DEPTH) - fcnt_q;

    always_comb begin
        rd_val = 16'h0000;
        case (sh_nxt[7:0])
            8'h00:   rd_val = mode_q;
            8'h0B:   rd_val = vol_q;
            default: rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 16'h0000;
            so_sh_q    <= 16'h0000;
            addr_q     <= 8'h00;
            wr_q       <= 1'b0;
            so_q       <= 1'b0;
            mode_q     <= 16'h0800;
            vol_q      <= 16'h0000;
            err_q      <= 1'b0;
            push_q     <= 1'b0;
            push_dat_q <= 8'h00;
            dreq_q     <= 1'b0;
        end else begin
            push_q <= 1'b0;
            dreq_q <= (free >= (AW+1)'(DREQ_FREE)) &&
                      !(wr_q && (state_q == SCI_DATA || state_q == SCI_WAIT));
            case (state_q)
                IDLE: begin
                    cnt_q <= 4'd0;
                    so_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    if (!xcs_s) begin
                        state_q <= SCI_OP;
                        if (!xdcs_s) err_q <= 1'b1;
                    end else if (!xdcs_s) begin
                        state_q <= SDI;
                    end
                end
                SCI_OP, SCI_ADDR, SCI_DATA: begin
                    if (xcs_s) begin
                        state_q <= IDLE;
                    end else if (rise) begin
                        sh_q  <= sh_nxt;
                        cnt_q <= cnt_q + 4'd1;
                        if (state_q == SCI_OP && cnt_q == 4'd7) begin
                            cnt_q <= 4'd0;
                            if (sh_nxt[7:0] == 8'h02 || sh_nxt[7:0] == 8'h03) begin
                                wr_q    <= ~sh_nxt[0];
                                state_q <= SCI_ADDR;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= SCI_WAIT;
                            end
                        end else if (state_q == SCI_ADDR && cnt_q == 4'd7) begin
                            cnt_q   <= 4'd0;
                            addr_q  <= sh_nxt[7:0];
                            state_q <= SCI_DATA;
                            if (!wr_q) begin
                                so_sh_q <= rd_val;
                                so_q    <= rd_val[15];
                            end
                        end else if (state_q == SCI_DATA && cnt_q == 4'd15) begin
                            if (wr_q && addr_q == 8'h00) mode_q <= sh_nxt;
                            if (wr_q && addr_q == 8'h0B) vol_q  <= sh_nxt;
                            state_q <= SCI_WAIT;
                        end
                    end else if (fall && state_q == SCI_DATA && cnt_q != 4'd0) begin
                        // Hold the MSB through the first data rise; shift only after it.
                        so_sh_q <= {so_sh_q[14:0], 1'b0};
                        so_q    <= so_sh_q[14];
                    end
                end
                SCI_WAIT: begin
                    if (xcs_s) state_q <= IDLE;
                end
                SDI: begin
                    if (xdcs_s) begin
                        state_q <= IDLE;
                    end else if (rise) begin
                        sh_q <= sh_nxt;
                        if (cnt_q == 4'd7) begin
                            cnt_q      <= 4'd0;
                            push_q     <= 1'b1;
                            push_dat_q <= sh_nxt[7:0];
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (push_ok && !pop)      fcnt_d = fcnt_q + (AW+1)'(1);
        else if (!push_ok && pop) fcnt_d = fcnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            if (push_ok) wp_q <= wp_q + AW'(1);
            if (pop)     rp_q <= rp_q + AW'(1);
            if (push_q && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= push_dat_q;
    end

    assign SO         = so_q;
    assign DREQ       = dreq_q;
    assign mode_reg   = mode_q;
    assign vol_reg    = vol_q;
    assign data_out   = mem_q[rp_q];
    assign data_valid = (fcnt_q != '0);
    assign sci_err    = err_q;
    assign overflow   = ovf_q;
endmodule
